// File: rtl/neuron.sv
// Fixed-point neuron stage: gathers N activations, forms a saturated Q8.8 dot product
// for the sigmoid block, and on a training pass applies the returned error to every weight.

module neuron_wlane (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst)    q <= '0;
    else if (we) q <= d;
endmodule

module neuron #(
  parameter int N    = 4,
  parameter int RATE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        arg_stb,
  input  logic [7:0]  arg_dat,
  output logic        arg_rdy,
  output logic        res_stb,
  output logic [15:0] res_dat,
  input  logic        res_rdy,
  input  logic        err_stb,
  input  logic [15:0] err_dat,
  output logic        err_rdy
);
  localparam int IW = $clog2(N);
  localparam int AW = 25 + IW;

  typedef enum logic [2:0] {ARG, MAC, RES, ERR, UPD} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]         idx;
  logic [N-1:0][7:0]     x;
  logic [N-1:0][15:0]    w;
  logic [N-1:0]          w_we;
  logic signed [AW-1:0]  acc, acc_nxt;
  logic signed [AW-9:0]  acc_sh;
  logic [15:0]           err, res_sat, w_new;
  logic [7:0]            x_cur;
  logic [15:0]           w_cur;
  logic signed [24:0]    x_ext, w_ext, e_ext, mac_prod, upd_prod, delta, w_sum;
  logic                  arg_ack, res_ack, err_ack, last;

  assign arg_rdy = (state == ARG);
  assign err_rdy = (state == ERR);
  assign arg_ack = arg_stb & arg_rdy;
  assign res_ack = res_stb & res_rdy;
  assign err_ack = err_stb & err_rdy;
  assign last    = (idx == IW'(N-1));

  // Shared datapath: both products fit in 25 bits, so a 25-bit multiply is exact.
  assign x_cur    = x[idx];
  assign w_cur    = w[idx];
  assign x_ext    = {17'b0, x_cur};
  assign w_ext    = {{9{w_cur[15]}}, w_cur};
  assign e_ext    = {{9{err[15]}}, err};
  assign mac_prod = x_ext * w_ext;
  assign upd_prod = x_ext * e_ext;
  assign acc_nxt  = acc + {{IW{mac_prod[24]}}, mac_prod};
  assign acc_sh   = acc_nxt[AW-1:8];
  assign delta    = upd_prod >>> (8 + RATE);
  assign w_sum    = w_ext + delta;

  always_comb begin
    res_sat = acc_sh[15:0];
    if (!(acc_sh[AW-9:15] == '0 || acc_sh[AW-9:15] == '1))
      res_sat = acc_sh[AW-9] ? 16'h8000 : 16'h7FFF;
  end

  always_comb begin
    w_new = w_sum[15:0];
    if (!(w_sum[24:15] == '0 || w_sum[24:15] == '1))
      w_new = w_sum[24] ? 16'h8000 : 16'h7FFF;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_w
    assign w_we[gi] = (state == UPD) && (idx == IW'(gi));
    neuron_wlane u_w (.clk(clk), .rst(rst), .we(w_we[gi]), .d(w_new), .q(w[gi]));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARG:     if (arg_ack && last) state_nxt = MAC;
      MAC:     if (last)            state_nxt = RES;
      RES:     if (res_ack)         state_nxt = en ? ERR : ARG;
      ERR:     if (err_ack)         state_nxt = UPD;
      UPD:     if (last)            state_nxt = ARG;
      default:                      state_nxt = ARG;
    endcase
  end

  // N is a power of two, so idx wraps to 0 after N-1 on its own.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= ARG;
      idx     <= '0;
      acc     <= '0;
      x       <= '0;
      err     <= '0;
      res_stb <= 1'b0;
      res_dat <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ARG: if (arg_ack) begin
          x[idx] <= arg_dat;
          idx    <= idx + 1'b1;
          if (last) acc <= '0;
        end
        MAC: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          // Register the result on the final MAC edge so it is valid in the first RES cycle.
          if (last) begin
            res_stb <= 1'b1;
            res_dat <= res_sat;
          end
        end
        RES: if (res_ack) res_stb <= 1'b0;
        ERR: if (err_ack) err <= err_dat;
        UPD: idx <= idx + 1'b1;
        default: idx <= '0;
      endcase
    end
endmodule

// File: tb/tb_neuron.sv
// Directed bench for neuron (N=4, RATE=0): latency, training, saturation, backpressure, reset abort.

module tb_neuron;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, en, arg_stb, res_rdy, err_stb;
  logic [7:0]  arg_dat;
  logic [15:0] err_dat, res_dat;
  logic        arg_rdy, res_stb, err_rdy;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] r;

  neuron #(.N(N), .RATE(0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
    .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
    .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; arg_stb = 1'b0; res_rdy = 1'b0; err_stb = 1'b0;
    arg_dat = '0; err_dat = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic send_x(input logic [7:0] v);
    int acks = 0;
    arg_dat = v; arg_stb = 1'b1;
    for (int i = 0; i < 40 && acks < N; i++) begin
      if (arg_rdy) acks++;
      tick();
    end
    arg_stb = 1'b0;
    n_checks++;
    if (acks != N) begin n_fail++; $display("FAIL send_x acks=%0d required=%0d", acks, N); end
  endtask

  task automatic wait_res();
    int k = 0;
    while (!res_stb && k < 50) begin tick(); k++; end
    n_checks++;
    if (res_stb !== 1'b1) begin n_fail++; $display("FAIL wait_res res_stb=%b required=1", res_stb); end
  endtask

  task automatic ack_res();
    res_rdy = 1'b1; tick(); res_rdy = 1'b0;
  endtask

  task automatic give_err(input logic [15:0] e);
    int k = 0;
    err_dat = e; err_stb = 1'b1;
    while (!err_rdy && k < 50) begin tick(); k++; end
    n_checks++;
    if (err_rdy !== 1'b1) begin n_fail++; $display("FAIL give_err err_rdy=%b required=1", err_rdy); end
    tick();
    err_stb = 1'b0;
  endtask

  task automatic wait_arg();
    int k = 0;
    while (!arg_rdy && k < 50) begin tick(); k++; end
    n_checks++;
    if (arg_rdy !== 1'b1) begin n_fail++; $display("FAIL wait_arg arg_rdy=%b required=1", arg_rdy); end
  endtask

  task automatic forward(input logic [7:0] v, output logic [15:0] res);
    en = 1'b0;
    send_x(v);
    wait_res();
    res = res_dat;
    ack_res();
  endtask

  task automatic train(input logic [7:0] v, input logic [15:0] e);
    en = 1'b1;
    send_x(v);
    wait_res();
    ack_res();
    en = 1'b0;
    give_err(e);
    wait_arg();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; arg_stb = 1'b0; res_rdy = 1'b0; err_stb = 1'b0;
    arg_dat = '0; err_dat = '0;
    #3;
    n_checks++; if (arg_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_arg_rdy got=%b exp=1", arg_rdy); end
    n_checks++; if (res_stb !== 1'b0) begin n_fail++; $display("FAIL reset_res_stb got=%b exp=0", res_stb); end
    n_checks++; if (res_dat !== 16'h0000) begin n_fail++; $display("FAIL reset_res_dat got=%h exp=0000", res_dat); end
    n_checks++; if (err_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_err_rdy got=%b exp=0", err_rdy); end
    tick(); rst = 1'b1; tick();
  endtask

  task automatic test_forward_latency();
    int err_seen = 0;
    do_reset();
    send_x(8'hFF);
    repeat (3) tick();
    n_checks++; if (res_stb !== 1'b0) begin n_fail++; $display("FAIL lat_early res_stb=%b exp=0", res_stb); end
    tick();
    n_checks++; if (res_stb !== 1'b1) begin n_fail++; $display("FAIL lat_on_time res_stb=%b exp=1", res_stb); end
    n_checks++; if (res_dat !== 16'h0000) begin n_fail++; $display("FAIL fwd_zero res_dat=%h exp=0000", res_dat); end
    tick();
    n_checks++; if (res_stb !== 1'b1) begin n_fail++; $display("FAIL hold_no_rdy res_stb=%b exp=1", res_stb); end
    ack_res();
    n_checks++; if (arg_rdy !== 1'b1) begin n_fail++; $display("FAIL en0_arg_rdy got=%b exp=1", arg_rdy); end
    n_checks++; if (res_stb !== 1'b0) begin n_fail++; $display("FAIL res_stb_drop got=%b exp=0", res_stb); end
    for (int i = 0; i < 6; i++) begin
      if (err_rdy) err_seen++;
      tick();
    end
    n_checks++; if (err_seen != 0) begin n_fail++; $display("FAIL en0_no_err err_rdy_cycles=%0d exp=0", err_seen); end
  endtask

  task automatic test_train_basic();
    do_reset();
    en = 1'b1;
    send_x(8'hFF);
    wait_res();
    ack_res();
    en = 1'b0;
    give_err(16'h0100);
    repeat (3) tick();
    n_checks++; if (arg_rdy !== 1'b0) begin n_fail++; $display("FAIL upd_len_early arg_rdy=%b exp=0", arg_rdy); end
    tick();
    n_checks++; if (arg_rdy !== 1'b1) begin n_fail++; $display("FAIL upd_len_on_time arg_rdy=%b exp=1", arg_rdy); end
    forward(8'h80, r);
    n_checks++; if (r !== 16'h01FE) begin n_fail++; $display("FAIL train_basic res_dat=%h exp=01FE", r); end
    forward(8'hFF, r);
    n_checks++; if (r !== 16'h03F8) begin n_fail++; $display("FAIL weights_persist res_dat=%h exp=03F8", r); end
  endtask

  task automatic test_saturate_pos();
    do_reset();
    train(8'hFF, 16'h7FFF);
    forward(8'h01, r);
    n_checks++; if (r !== 16'h01FD) begin n_fail++; $display("FAIL pos_step1 res_dat=%h exp=01FD", r); end
    train(8'hFF, 16'h7FFF);
    forward(8'h01, r);
    n_checks++; if (r !== 16'h01FF) begin n_fail++; $display("FAIL pos_wsat res_dat=%h exp=01FF", r); end
    forward(8'hFF, r);
    n_checks++; if (r !== 16'h7FFF) begin n_fail++; $display("FAIL pos_ressat res_dat=%h exp=7FFF", r); end
  endtask

  task automatic test_saturate_neg();
    do_reset();
    train(8'hFF, 16'h8000);
    forward(8'h01, r);
    n_checks++; if (r !== 16'hFE02) begin n_fail++; $display("FAIL neg_step res_dat=%h exp=FE02", r); end
    forward(8'hFF, r);
    n_checks++; if (r !== 16'h8000) begin n_fail++; $display("FAIL neg_ressat res_dat=%h exp=8000", r); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    train(8'hFF, 16'h0100);
    en = 1'b1;
    send_x(8'h80);
    wait_res();
    arg_dat = 8'h00; arg_stb = 1'b1;
    err_dat = 16'h7FFF; err_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (res_stb !== 1'b1 || res_dat !== 16'h01FE || arg_rdy !== 1'b0 || err_rdy !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    err_stb = 1'b0;
    ack_res();
    n_checks++; if (err_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_err_state err_rdy=%b exp=1", err_rdy); end
    give_err(16'h0100);
    repeat (3) tick();
    arg_stb = 1'b0;
    wait_arg();
    forward(8'h01, r);
    n_checks++; if (r !== 16'h0005) begin n_fail++; $display("FAIL bp_x_kept res_dat=%h exp=0005", r); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    train(8'hFF, 16'h0100);
    res_rdy = 1'b1; en = 1'b1;
    send_x(8'h80);
    repeat (3) tick();
    en = 1'b0;
    tick();
    n_checks++; if (res_stb !== 1'b1 || res_dat !== 16'h01FE) begin
      n_fail++; $display("FAIL rdy_early_pulse stb=%b dat=%h exp stb=1 dat=01FE", res_stb, res_dat);
    end
    tick();
    res_rdy = 1'b0;
    n_checks++; if (res_stb !== 1'b0) begin n_fail++; $display("FAIL rdy_early_width res_stb=%b exp=0", res_stb); end
    n_checks++; if (err_rdy !== 1'b0 || arg_rdy !== 1'b1) begin
      n_fail++; $display("FAIL en_sample_low err_rdy=%b arg_rdy=%b exp 0/1", err_rdy, arg_rdy);
    end
    en = 1'b0;
    send_x(8'h80);
    wait_res();
    en = 1'b1;
    ack_res();
    en = 1'b0;
    n_checks++; if (err_rdy !== 1'b1) begin n_fail++; $display("FAIL en_sample_high err_rdy=%b exp=1", err_rdy); end
    give_err(16'h0000);
    wait_arg();
    forward(8'h80, r);
    n_checks++; if (r !== 16'h01FE) begin n_fail++; $display("FAIL zero_err_update res_dat=%h exp=01FE", r); end
  endtask

  task automatic test_reset_mid_mac();
    int stb_seen = 0;
    do_reset();
    train(8'hFF, 16'h0100);
    en = 1'b0;
    send_x(8'hFF);
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (res_stb !== 1'b0 || res_dat !== 16'h0000 || arg_rdy !== 1'b1 || err_rdy !== 1'b0) begin
      n_fail++; $display("FAIL mid_mac_reset stb=%b dat=%h arg_rdy=%b err_rdy=%b exp 0/0000/1/0",
                         res_stb, res_dat, arg_rdy, err_rdy);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (res_stb) stb_seen++;
      tick();
    end
    n_checks++; if (stb_seen != 0) begin n_fail++; $display("FAIL abort_no_result res_stb_cycles=%0d exp=0", stb_seen); end
    forward(8'hFF, r);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL abort_weights res_dat=%h exp=0000", r); end
  endtask

  initial begin
    test_reset();
    test_forward_latency();
    test_train_basic();
    test_saturate_pos();
    test_saturate_neg();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
